shift_reg_seq_ctrl: RTL and testbench

Sequencer for the common universal shift register: it turns one parallel command word into a timed serial exchange.
- Loads the word into the register, then shifts it out LSB-first or MSB-first at a programmable bit rate.
- Captures the incoming serial bits through the same register and returns the received word on a response handshake.
- Sits between a host-side valid/ready command interface and one shift register instance, driving that register's select and serial-in pins.

---
 rtl/shift_reg_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_shift_reg_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq_ctrl.sv
// shift_reg_seq_ctrl: sequences one command word through a universal shift register as a timed serial exchange
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/ready/data/len/msb_first, cfg_div   host command (accepted in IDLE only)
//   sr_select, sr_p_din, sr_s_left_din, sr_s_right_din   drive the shift register
//   sr_p_dout, sr_s_left_dout, sr_s_right_dout           from the shift register
//   ser_tx, ser_rx, ser_strobe      serial line and per-bit strobe
//   busy                            command in progress
//   rsp_valid/ready/data            received word handshake
module shift_reg_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_msb_first,
   input  logic [DIV_W-1:0] cfg_div,
   output logic [1:0]       sr_select,
   output logic [WIDTH-1:0] sr_p_din,
   output logic             sr_s_left_din,
   output logic             sr_s_right_din,
   input  logic [WIDTH-1:0] sr_p_dout,
   input  logic             sr_s_left_dout,
   input  logic             sr_s_right_dout,
   output logic             ser_tx,
   input  logic             ser_rx,
   output logic             ser_strobe,
   output logic             busy,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   localparam logic [LEN_W-1:0] WL = LEN_W'(WIDTH);
   state_t state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d, bits_q, bits_d, eff_len;
   logic [WIDTH-1:0] data_q, data_d;
   logic msb_q, msb_d, strobe;
   assign eff_len = (cmd_len == '0 || cmd_len > WL) ? WL : cmd_len;
   assign strobe = state_q == SHIFT && cnt_q == div_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         bits_q  <= '0;
         data_q  <= '0;
         msb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         bits_q  <= bits_d;
         data_q  <= data_d;
         msb_q   <= msb_d;
      end
   end
   always_comb begin
      state_d        = state_q;
      div_d          = div_q;
      cnt_d          = cnt_q;
      len_d          = len_q;
      bits_d         = bits_q;
      data_d         = data_q;
      msb_d          = msb_q;
      cmd_ready      = state_q == IDLE;
      busy           = state_q != IDLE;
      rsp_valid      = state_q == DONE;
      sr_select      = 2'b00;
      sr_p_din       = '0;
      sr_s_left_din  = 1'b0;
      sr_s_right_din = 1'b0;
      ser_tx         = 1'b0;
      ser_strobe     = 1'b0;
      rsp_data       = '0;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d = LOAD;
            len_d   = eff_len;
            msb_d   = cmd_msb_first;
            div_d   = cfg_div;
            cnt_d   = '0;
            bits_d  = '0;
            // MSB-first: left-align the L-bit word so its top bit sits at the register MSB
            data_d  = cmd_msb_first ? cmd_data << (WL - eff_len) : cmd_data;
         end
         LOAD: begin
            sr_select = 2'b11;
            sr_p_din  = data_q;
            state_d   = SHIFT;
         end
         SHIFT: begin
            ser_tx = msb_q ? sr_s_right_dout : sr_s_left_dout;
            cnt_d  = strobe ? '0 : cnt_q + DIV_W'(1);
            if (strobe) begin
               ser_strobe     = 1'b1;
               sr_select      = msb_q ? 2'b10 : 2'b01;
               sr_s_left_din  = msb_q & ser_rx;
               sr_s_right_din = ~msb_q & ser_rx;
               bits_d         = bits_q + LEN_W'(1);
               if (bits_q == len_q - LEN_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            // LSB-first receive enters at the MSB end; MSB-first fills the low L bits
            rsp_data = msb_q ? sr_p_dout & ~({WIDTH{1'b1}} << len_q) : sr_p_dout >> (WL - len_q);
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// tb_shift_reg_seq_ctrl: self-checking bench for shift_reg_seq_ctrl with a behavioural universal shift register
module tb_shift_reg_seq_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready, cmd_msb_first = 1'b0;
   logic [7:0] cmd_data = '0, cfg_div = '0;
   logic [3:0] cmd_len = '0;
   logic [1:0] sr_select;
   logic [7:0] sr_p_din, sr_p_dout, rsp_data;
   logic sr_s_left_din, sr_s_right_din, sr_s_left_dout, sr_s_right_dout;
   logic ser_tx, ser_rx, ser_strobe, busy, rsp_valid, rsp_ready = 1'b1;
   logic [1:0] rx_mode = 2'd0;
   logic [7:0] sr_q;
   int checks = 0, errors = 0;
   int strobe_total = 0, sel_bad = 0;
   logic tx_log [1024];
   logic [7:0] sb [$];

   typedef struct {
      logic [3:0] len;
      logic       msb;
      logic [7:0] data;
      logic [7:0] div;
      logic [1:0] rx;
      logic [7:0] rsp;
   } vec_t;
   vec_t vecs [10];

   always #5 clk = ~clk;

   shift_reg_seq_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_len(cmd_len),
      .cmd_msb_first(cmd_msb_first), .cfg_div(cfg_div),
      .sr_select(sr_select), .sr_p_din(sr_p_din), .sr_s_left_din(sr_s_left_din),
      .sr_s_right_din(sr_s_right_din), .sr_p_dout(sr_p_dout),
      .sr_s_left_dout(sr_s_left_dout), .sr_s_right_dout(sr_s_right_dout),
      .ser_tx(ser_tx), .ser_rx(ser_rx), .ser_strobe(ser_strobe), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
   );

   // universal shift register: 01 right (enters at MSB), 10 left (enters at LSB), 11 load
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else if (sr_select == 2'b01) sr_q <= {sr_s_right_din, sr_q[7:1]};
      else if (sr_select == 2'b10) sr_q <= {sr_q[6:0], sr_s_left_din};
      else if (sr_select == 2'b11) sr_q <= sr_p_din;
   end
   assign sr_p_dout = sr_q;
   assign sr_s_left_dout = sr_q[0];
   assign sr_s_right_dout = sr_q[7];
   assign ser_rx = rx_mode == 2'd0 ? ser_tx : rx_mode == 2'd1;

   always @(negedge clk) begin
      if (ser_strobe) begin
         if (strobe_total < 1024) tx_log[strobe_total] = ser_tx;
         strobe_total = strobe_total + 1;
      end
      if (busy && (ser_strobe != (sr_select == 2'b01 || sr_select == 2'b10))) sel_bad = sel_bad + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rsp_valid && n < 2000);
      if (n >= 2000) chk("rsp_timeout", 32'd1, 32'd0);
   endtask

   task automatic check_rsp();
      chk("rsp_valid", rsp_valid, 1);
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("rsp_data", rsp_data, sb.pop_front());
   endtask

   task automatic run_vec(input vec_t v);
      int el, n, base, bad0;
      logic [7:0] exp_tx, got_tx, d;
      el = (v.len == 0 || v.len > 8) ? 8 : int'(v.len);
      d = v.data;
      @(posedge clk);
      #1;
      cmd_data = v.data; cmd_len = v.len; cmd_msb_first = v.msb; cfg_div = v.div; rx_mode = v.rx;
      cmd_valid = 1'b1;
      sb.push_back(v.rsp);
      @(negedge clk);
      chk("cmd_ready", cmd_ready, 1);
      base = strobe_total;
      bad0 = sel_bad;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cfg_div = ~v.div;
      wait_rsp(n);
      chk("latency", n, el * (int'(v.div) + 1) + 1);
      @(negedge clk);
      check_rsp();
      chk("strobes", strobe_total - base, el);
      exp_tx = '0;
      got_tx = '0;
      for (int k = 0; k < el; k++) begin
         exp_tx[k] = v.msb ? d[el-1-k] : d[k];
         got_tx[k] = tx_log[base+k];
      end
      chk("tx_bits", got_tx, exp_tx);
      chk("sel_strobe", sel_bad - bad0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, base;
      vecs[0] = '{4'd0,  1'b0, 8'hA5, 8'd0, 2'd0, 8'hA5};
      vecs[1] = '{4'd4,  1'b1, 8'h0C, 8'd0, 2'd1, 8'h0F};
      vecs[2] = '{4'd8,  1'b0, 8'h96, 8'd3, 2'd0, 8'h96};
      vecs[3] = '{4'd15, 1'b0, 8'hA5, 8'd0, 2'd0, 8'hA5};
      vecs[4] = '{4'd1,  1'b1, 8'h01, 8'd2, 2'd2, 8'h00};
      vecs[5] = '{4'd1,  1'b0, 8'h00, 8'd0, 2'd1, 8'h01};
      vecs[6] = '{4'd3,  1'b0, 8'h06, 8'd1, 2'd0, 8'h06};
      vecs[7] = '{4'd7,  1'b1, 8'h55, 8'd0, 2'd0, 8'h55};
      vecs[8] = '{4'd5,  1'b1, 8'hFF, 8'd1, 2'd2, 8'h00};
      vecs[9] = '{4'd8,  1'b1, 8'h3C, 8'd0, 2'd0, 8'h3C};
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_sel", sr_select, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_strobe", ser_strobe, 0);
      chk("rst_tx", ser_tx, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) run_vec(vecs[i]);
      // backpressure: response held while a new command waits
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      cmd_data = 8'h09; cmd_len = 4'd4; cmd_msb_first = 1'b0; cfg_div = 8'd0; rx_mode = 2'd0;
      cmd_valid = 1'b1;
      sb.push_back(8'h09);
      @(posedge clk);
      #1;
      cmd_data = 8'h3C; cmd_len = 4'd0;
      wait_rsp(n);
      chk("bp_latency", n, 5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_data", rsp_data, 8'h09);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_sel", sr_select, 0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check_rsp();
      sb.push_back(8'h3C);
      @(negedge clk);
      chk("bp_cmd_ready_after", cmd_ready, 1);
      chk("bp_idle", busy, 0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_load", sr_select, 2'b11);
      wait_rsp(n);
      chk("bp2_latency", n, 9);
      @(negedge clk);
      check_rsp();
      // reset mid-SHIFT after the third strobe
      @(posedge clk);
      #1;
      cmd_data = 8'hA5; cmd_len = 4'd0; cmd_msb_first = 1'b0; cfg_div = 8'd1; rx_mode = 2'd0;
      cmd_valid = 1'b1;
      base = strobe_total;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (strobe_total - base < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("mid_strobe3_seen", strobe_total - base >= 3, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_sel", sr_select, 0);
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_sr_cleared", sr_p_dout, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_cmd_ready", cmd_ready, 1);
      chk("mid_rsp_after", rsp_valid, 0);
      run_vec('{4'd0, 1'b0, 8'h3C, 8'd0, 2'd0, 8'h3C});
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
